// File: rtl/clk_div_prog.sv
// clk_div_prog -- programmable CPU clock: free-running divider taps (fast/slow), debounced single step, hold.
// Latency: every output is a flop; MODE and STEP_BTN pass a 2-flop synchronizer before any use.
// Backpressure: none; the block free-runs and samples its inputs on every CLK.
//
// Ports:
//   CLK        system clock, all flops on its rising edge
//   RST_N      asynchronous active-low reset
//   MODE       requested mode (00 fast, 01 slow, 10 single-step, 11 hold), asynchronous
//   STEP_BTN   raw, bouncing step push-button, asynchronous, active-high
//   CLK_CPU    divided CPU clock
//   CPU_EN     one-CLK pulse in the cycle CLK_CPU goes 0->1
//   TICK_CNT   CLK_CPU rising edges since reset, wrapping
//   MODE_ACT   mode currently driving CLK_CPU
module clk_div_prog #(
  parameter int CNT_W    = 32,
  parameter int TAP_FAST = 21,
  parameter int TAP_SLOW = 29,
  parameter int DB_W     = 20,
  parameter int STEP_HI  = 16,
  parameter int TICK_W   = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [1:0]        MODE,
  input  logic              STEP_BTN,
  output logic              CLK_CPU,
  output logic              CPU_EN,
  output logic [TICK_W-1:0] TICK_CNT,
  output logic [1:0]        MODE_ACT
);

  typedef enum logic [1:0] {
    M_FAST = 2'b00,
    M_SLOW = 2'b01,
    M_STEP = 2'b10,
    M_HOLD = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HIGH = 1'b1
  } step_e;

  localparam logic [15:0] STEP_LAST = 16'(STEP_HI - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [1:0]        r_mode_s1;
  logic [1:0]        r_mode_s2;
  logic              r_btn_s1;
  logic              r_btn_s2;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_db_lvl;
  logic              r_db_lvl_d;
  logic [1:0]        r_rel_cnt;
  mode_e             r_mode_act;
  step_e             r_step_st;
  logic [15:0]       r_step_tmr;
  logic              r_clk_cpu;
  logic              r_cpu_en;
  logic [TICK_W-1:0] r_tick;

  mode_e             w_mode_sync;
  mode_e             w_mode_nxt;
  logic              w_rel_ok;
  logic              w_db_rise;
  logic              w_step_busy;
  logic              w_new_tgt;
  logic              w_switch;
  logic              w_tgt;
  logic              w_rise;

  // Level a mode would put on CLK_CPU. Divider taps look at the counter value
  // being loaded this cycle so CLK_CPU tracks the tap bit with no extra lag.
  function automatic logic f_tgt(input mode_e m, input logic [CNT_W-1:0] c, input step_e st);
    logic v;
    v = 1'b0;
    case (m)
      M_FAST:  v = c[TAP_FAST];
      M_SLOW:  v = c[TAP_SLOW];
      M_STEP:  v = (st == ST_HIGH);
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_mode_sync = mode_e'(r_mode_s2);
  // The synchronizers hold reset values for two edges after release; ignore them until then.
  assign w_rel_ok    = (r_rel_cnt == 2'd2);
  assign w_db_rise   = r_db_lvl & ~r_db_lvl_d;
  // A pending or running step pulse pins the mode until it has fully completed.
  assign w_step_busy = (r_mode_act == M_STEP) && (r_step_st == ST_HIGH);

  always_comb begin
    w_new_tgt  = f_tgt(w_mode_sync, w_cnt_nxt, r_step_st);
    // Switch only while both the present clock and the incoming mode are low:
    // no high phase is cut short and the new mode starts at the beginning of a low phase.
    w_switch   = w_rel_ok && (w_mode_sync != r_mode_act) && !r_clk_cpu && !w_new_tgt && !w_step_busy;
    w_mode_nxt = w_switch ? w_mode_sync : r_mode_act;
    w_tgt      = f_tgt(w_mode_nxt, w_cnt_nxt, r_step_st);
    w_rise     = w_tgt & ~r_clk_cpu;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      r_mode_s1 <= 2'b00;
      r_mode_s2 <= 2'b00;
      r_btn_s1  <= 1'b0;
      r_btn_s2  <= 1'b0;
      r_rel_cnt <= 2'd0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_mode_s1 <= MODE;
      r_mode_s2 <= r_mode_s1;
      r_btn_s1  <= STEP_BTN;
      r_btn_s2  <= r_btn_s1;
      if (r_rel_cnt != 2'd2) begin
        r_rel_cnt <= r_rel_cnt + 2'd1;
      end
    end
  end

  // Debounce: the level flips on the 2^DB_W-th consecutive cycle of disagreement.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_db_cnt   <= '0;
      r_db_lvl   <= 1'b0;
      r_db_lvl_d <= 1'b0;
    end else begin
      r_db_lvl_d <= r_db_lvl;
      if (r_btn_s2 != r_db_lvl) begin
        if (&r_db_cnt) begin
          r_db_lvl <= r_btn_s2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Step FSM: HIGH lasts STEP_HI cycles; CLK_CPU follows it one cycle later for the same length.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_step_st  <= ST_IDLE;
      r_step_tmr <= '0;
    end else if (w_mode_nxt != M_STEP) begin
      r_step_st  <= ST_IDLE;
      r_step_tmr <= '0;
    end else begin
      case (r_step_st)
        ST_IDLE: begin
          if (w_db_rise && (r_mode_act == M_STEP)) begin
            r_step_st  <= ST_HIGH;
            r_step_tmr <= '0;
          end
        end
        ST_HIGH: begin
          if (r_step_tmr == STEP_LAST) begin
            r_step_st  <= ST_IDLE;
            r_step_tmr <= '0;
          end else begin
            r_step_tmr <= r_step_tmr + 16'd1;
          end
        end
        default: begin
          r_step_st  <= ST_IDLE;
          r_step_tmr <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mode_act <= M_HOLD;
      r_clk_cpu  <= 1'b0;
      r_cpu_en   <= 1'b0;
      r_tick     <= '0;
    end else begin
      r_mode_act <= w_mode_nxt;
      r_clk_cpu  <= w_tgt;
      r_cpu_en   <= w_rise;
      if (w_rise) begin
        r_tick <= r_tick + TICK_W'(1);
      end
    end
  end

  assign CLK_CPU  = r_clk_cpu;
  assign CPU_EN   = r_cpu_en;
  assign TICK_CNT = r_tick;
  assign MODE_ACT = r_mode_act;

endmodule
